mm_reg_bridge: RTL and testbench

Converts single-word CPU load/store requests into the two-channel Wishbone register-bus accesses consumed by the `peripherals` block (UART, GPIO, interrupt, I2C registers). It sits directly upstream of `peripherals`, between the core's data-memory port and the MM register file. It decodes the MM register window, issues exactly one read strobe or one write-enable pulse per access, and waits for the acknowledge. It then returns data, or an error on decode miss or timeout.

---
 rtl/mm_reg_bridge_pkg.sv | 16 +
 rtl/mm_bus_watchdog.sv | 33 +++
 rtl/mm_reg_bridge.sv | 158 +++++++++++++++
 tb/tb_mm_reg_bridge.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_reg_bridge_pkg.sv
// Shared types and constants for the MM register bridge.
package mm_reg_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StWrIssue,
    StRdWait,
    StWrWait,
    StResp
  } mm_bridge_state_t;

  localparam logic [31:0] MM_BASE_DEFAULT  = 32'h8000_0000;
  localparam int unsigned MM_TIMEOUT_CNT_W = $clog2(256);

endpackage

// File: rtl/mm_bus_watchdog.sv
// Ack-wait cycle counter for the register bridge; asserts o_expired on the last allowed
// wait cycle when no ack is present. Only used when MM_BRIDGE_TIMEOUT_EN is defined.
module mm_bus_watchdog
  import mm_reg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_clear,
  input  logic i_ack,
  output logic o_expired
);

  localparam logic [MM_TIMEOUT_CNT_W-1:0] LastCount = MM_TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [MM_TIMEOUT_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= r_count + 1'b1;
    end
  end

  // An ack in the expiry cycle takes priority, so it masks expiry here.
  assign o_expired = i_start && !i_ack && (r_count == LastCount);

endmodule

// File: rtl/mm_reg_bridge.sv
// CPU load/store to two-channel Wishbone register-bus bridge with window decode.
// Optional ack timeout is built when MM_BRIDGE_TIMEOUT_EN is defined.
module mm_reg_bridge
  import mm_reg_bridge_pkg::*;
#(
  parameter int unsigned MM_REG_ADDR_BITS = 8,
  parameter int unsigned ADDR_BITS        = MM_REG_ADDR_BITS,
  parameter logic [31:0] MM_BASE          = MM_BASE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [31:0]          mem_addr,
  input  logic [3:0]           mem_byte_en,
  input  logic [31:0]          mem_wdata,
  output logic                 req_ready,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic                 mem_error,
  output logic                 WB_RD_STB_O,
  output logic [ADDR_BITS-1:0] WB_RD_ADR_O,
  input  logic [31:0]          WB_RD_DAT_I,
  input  logic                 WB_RD_ACK_I,
  output logic                 WB_WR_STB_O,
  output logic                 WB_WR_WE_O,
  output logic [3:0]           WB_WR_SEL_O,
  output logic [ADDR_BITS-1:0] WB_WR_ADR_O,
  output logic [31:0]          WB_WR_DAT_O,
  input  logic                 WB_WR_ACK_I
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  mm_bridge_state_t     r_state, w_state_d;
  logic                 w_hit, w_ack, w_expired, w_unused_addr_lsb;
  logic                 r_req_ready, r_mem_ready, r_mem_error, r_rd_stb, r_wr_stb;
  logic [31:0]          r_mem_rdata, r_wdata;
  logic [ADDR_BITS-1:0] r_adr;
  logic [3:0]           r_sel;
  logic                 w_mem_ready_d, w_mem_error_d, w_rd_stb_d, w_wr_stb_d;
  logic [31:0]          w_mem_rdata_d, w_wdata_d;
  logic [ADDR_BITS-1:0] w_adr_d;
  logic [3:0]           w_sel_d;

  assign w_hit = (mem_addr[31:ADDR_BITS+2] == MM_BASE[31:ADDR_BITS+2]);
  assign w_ack = ((r_state == StRdWait) && WB_RD_ACK_I) || ((r_state == StWrWait) && WB_WR_ACK_I);
  assign w_unused_addr_lsb = ^mem_addr[1:0];

`ifdef MM_BRIDGE_TIMEOUT_EN
  logic w_in_wait;
  assign w_in_wait = (r_state == StRdWait) || (r_state == StWrWait);

  mm_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_in_wait),
    .i_clear  (sync_reset || !w_in_wait),
    .i_ack    (w_ack),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (mem_req) begin
          w_state_d = !w_hit ? StResp : (mem_we ? StWrIssue : StRdIssue);
        end
      end
      StRdIssue: w_state_d = StRdWait;
      StWrIssue: w_state_d = StWrWait;
      StRdWait,
      StWrWait: begin
        if (w_ack || w_expired) w_state_d = StResp;
      end
      StResp:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (sync_reset) w_state_d = StIdle;
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    w_rd_stb_d    = (w_state_d == StRdIssue);
    w_wr_stb_d    = (w_state_d == StWrIssue);
    w_mem_ready_d = (w_state_d == StResp);
    w_mem_error_d = w_mem_ready_d && !w_ack;
    w_mem_rdata_d = (w_mem_ready_d && w_ack && (r_state == StRdWait)) ? WB_RD_DAT_I : '0;
    w_adr_d       = r_adr;
    w_sel_d       = r_sel;
    w_wdata_d     = r_wdata;
    if (w_rd_stb_d || w_wr_stb_d) begin
      w_adr_d   = mem_addr[ADDR_BITS+1:2];
      w_sel_d   = mem_byte_en;
      w_wdata_d = mem_wdata;
    end
    if (sync_reset) begin
      w_adr_d   = '0;
      w_sel_d   = '0;
      w_wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_ready <= 1'b1;
      r_mem_ready <= 1'b0;
      r_mem_error <= 1'b0;
      r_mem_rdata <= '0;
      r_rd_stb    <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_adr       <= '0;
      r_sel       <= '0;
      r_wdata     <= '0;
    end else begin
      r_req_ready <= (w_state_d == StIdle);
      r_mem_ready <= w_mem_ready_d;
      r_mem_error <= w_mem_error_d;
      r_mem_rdata <= w_mem_rdata_d;
      r_rd_stb    <= w_rd_stb_d;
      r_wr_stb    <= w_wr_stb_d;
      r_adr       <= w_adr_d;
      r_sel       <= w_sel_d;
      r_wdata     <= w_wdata_d;
    end
  end

  assign req_ready   = r_req_ready;
  assign mem_ready   = r_mem_ready;
  assign mem_rdata   = r_mem_rdata;
  assign mem_error   = r_mem_error;
  assign WB_RD_STB_O = r_rd_stb;
  assign WB_RD_ADR_O = r_adr;
  assign WB_WR_STB_O = r_wr_stb;
  assign WB_WR_WE_O  = r_wr_stb;
  assign WB_WR_SEL_O = r_sel;
  assign WB_WR_ADR_O = r_adr;
  assign WB_WR_DAT_O = r_wdata;

endmodule

// File: tb/tb_mm_reg_bridge.sv
// Self-checking bench for mm_reg_bridge; expectations for MM_BRIDGE_TIMEOUT_EN follow the
// macro as seen by this file.
module tb_mm_reg_bridge;

  localparam int unsigned AB   = 8;
  localparam int unsigned TO   = 15;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef MM_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, sync_reset, mem_req, mem_we;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_byte_en;
  logic          req_ready, mem_ready, mem_error;
  logic          WB_RD_STB_O, WB_RD_ACK_I, WB_WR_STB_O, WB_WR_WE_O, WB_WR_ACK_I;
  logic [AB-1:0] WB_RD_ADR_O, WB_WR_ADR_O;
  logic [31:0]   WB_RD_DAT_I, WB_WR_DAT_O;
  logic [3:0]    WB_WR_SEL_O;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] slv_mem [256];

  always #5 clk = ~clk;

  mm_reg_bridge #(
    .MM_REG_ADDR_BITS(AB),
    .ADDR_BITS       (AB),
    .MM_BASE         (BASE),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_byte_en(mem_byte_en),
    .mem_wdata  (mem_wdata),
    .req_ready  (req_ready),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_error  (mem_error),
    .WB_RD_STB_O(WB_RD_STB_O),
    .WB_RD_ADR_O(WB_RD_ADR_O),
    .WB_RD_DAT_I(WB_RD_DAT_I),
    .WB_RD_ACK_I(WB_RD_ACK_I),
    .WB_WR_STB_O(WB_WR_STB_O),
    .WB_WR_WE_O (WB_WR_WE_O),
    .WB_WR_SEL_O(WB_WR_SEL_O),
    .WB_WR_ADR_O(WB_WR_ADR_O),
    .WB_WR_DAT_O(WB_WR_DAT_O),
    .WB_WR_ACK_I(WB_WR_ACK_I)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = d[b*8 +: 8];
    return old;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sync_reset = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_byte_en = '0; mem_wdata = '0;
    WB_RD_ACK_I = 1'b0; WB_WR_ACK_I = 1'b0; WB_RD_DAT_I = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, mem_ready, mem_error, WB_RD_STB_O, WB_WR_STB_O, WB_WR_WE_O} !== 6'b100000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 100000",
               {req_ready, mem_ready, mem_error, WB_RD_STB_O, WB_WR_STB_O, WB_WR_WE_O});
    end
    n_checks++;
    if ({mem_rdata, WB_RD_ADR_O, WB_WR_ADR_O, WB_WR_SEL_O, WB_WR_DAT_O} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got rdata=%h radr=%h wadr=%h sel=%h wdat=%h expected all 0",
               mem_rdata, WB_RD_ADR_O, WB_WR_ADR_O, WB_WR_SEL_O, WB_WR_DAT_O);
    end
    reset_n = 1'b1;
    step();
    step();
    n_checks++;
    if ({req_ready, mem_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL post_reset_idle: got ready=%b,%b expected 1,0", req_ready, mem_ready);
    end
  endtask

  // One access against the model: hit/miss, latency, data, error and bus-pulse counts.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input int ack_dly, input bit stray,
                            input string tag);
    bit            hit;
    int            exp_cyc, last, rd_n, wr_n, rdy_n, rdy_cyc, bad;
    logic [AB-1:0] wadr;
    logic          exp_err, got_err, got_rr;
    logic [31:0]   exp_rdata, got_rdata;
    hit  = (((addr ^ BASE) >> (AB + 2)) == 0);
    wadr = addr[AB+1:2];
    if (!hit) begin
      exp_cyc = 1; exp_err = 1'b1; exp_rdata = '0;
    end else if (TO_EN && ack_dly > int'(TO)) begin
      exp_cyc = 2 + int'(TO); exp_err = 1'b1; exp_rdata = '0;
    end else begin
      exp_cyc = 2 + ack_dly; exp_err = 1'b0; exp_rdata = we ? 32'h0 : ref_mem[wadr];
    end
    if (hit && we) ref_mem[wadr] = merge(ref_mem[wadr], wdata, be);
    last = ((exp_cyc > ack_dly + 1) ? exp_cyc : ack_dly + 1) + 2;
    rd_n = 0; wr_n = 0; rdy_n = 0; rdy_cyc = -1; bad = 0;
    got_err = 1'bx; got_rdata = 'x; got_rr = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s req_ready_before: got %b expected 1", tag, req_ready);
    end
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_byte_en = be; mem_wdata = wdata;
    for (int cyc = 1; cyc <= last; cyc++) begin
      step();
      mem_req = stray && (cyc < exp_cyc);
      if (mem_req) begin
        mem_we      = 1'($urandom_range(0, 1));
        mem_addr    = BASE | ($urandom_range(0, 255) << 2);
        mem_byte_en = 4'($urandom);
        mem_wdata   = $urandom;
      end
      if (WB_RD_STB_O) begin
        rd_n++;
        if (WB_RD_ADR_O !== wadr) bad++;
      end
      if (WB_WR_WE_O) begin
        wr_n++;
        if (WB_WR_STB_O !== 1'b1 || WB_WR_SEL_O !== be || WB_WR_DAT_O !== wdata ||
            WB_WR_ADR_O !== wadr) bad++;
        slv_mem[WB_WR_ADR_O] = merge(slv_mem[WB_WR_ADR_O], WB_WR_DAT_O, WB_WR_SEL_O);
      end
      if (hit && cyc < exp_cyc) begin
        if (!we && WB_RD_ADR_O !== wadr) bad++;
        if (we && (WB_WR_ADR_O !== wadr || WB_WR_SEL_O !== be || WB_WR_DAT_O !== wdata)) bad++;
      end
      if (mem_ready) begin
        rdy_n++; rdy_cyc = cyc; got_rdata = mem_rdata; got_err = mem_error;
      end
      if (cyc == exp_cyc + 1) got_rr = req_ready;
      WB_RD_ACK_I = hit && !we && (cyc == ack_dly + 1);
      WB_WR_ACK_I = hit && we && (cyc == ack_dly + 1);
      WB_RD_DAT_I = WB_RD_ACK_I ? slv_mem[WB_RD_ADR_O] : $urandom;
    end
    WB_RD_ACK_I = 1'b0; WB_WR_ACK_I = 1'b0; mem_req = 1'b0;
    n_checks++;
    if (rdy_n !== 1) begin
      n_errors++; $display("FAIL %s ready_count: got %0d expected 1", tag, rdy_n);
    end
    n_checks++;
    if (rdy_cyc !== exp_cyc) begin
      n_errors++; $display("FAIL %s latency: got %0d expected %0d", tag, rdy_cyc, exp_cyc);
    end
    n_checks++;
    if (got_rdata !== exp_rdata) begin
      n_errors++; $display("FAIL %s rdata: got %h expected %h", tag, got_rdata, exp_rdata);
    end
    n_checks++;
    if (got_err !== exp_err) begin
      n_errors++; $display("FAIL %s error: got %b expected %b", tag, got_err, exp_err);
    end
    n_checks++;
    if (rd_n !== int'(hit && !we)) begin
      n_errors++; $display("FAIL %s rd_strobes: got %0d expected %0d", tag, rd_n, hit && !we);
    end
    n_checks++;
    if (wr_n !== int'(hit && we)) begin
      n_errors++; $display("FAIL %s wr_enables: got %0d expected %0d", tag, wr_n, hit && we);
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL %s bus_fields: got %0d bad cycles expected 0", tag, bad);
    end
    n_checks++;
    if (got_rr !== 1'b1) begin
      n_errors++; $display("FAIL %s req_ready_after: got %b expected 1", tag, got_rr);
    end
  endtask

  task automatic test_directed();
    ref_mem[4] = 32'hA5A5_0001;
    slv_mem[4] = 32'hA5A5_0001;
    run_access(1'b0, 32'h8000_0010, 4'hF, 32'h0, 1, 1'b0, "load_word4");
    run_access(1'b1, 32'h8000_0000, 4'b0001, 32'h0000_0041, 1, 1'b0, "store_byte0");
    run_access(1'b0, 32'h8000_0000, 4'hF, 32'h0, 1, 1'b0, "load_back_word0");
    run_access(1'b0, 32'h4000_0000, 4'hF, 32'h0, 1, 1'b0, "decode_miss");
    run_access(1'b1, 32'h8000_0400, 4'hF, 32'h1234_5678, 1, 1'b0, "store_miss_above");
  endtask

  task automatic test_timeout();
    run_access(1'b0, 32'h8000_0020, 4'hF, 32'h0, 20, 1'b0, "rd_no_ack_late");
    run_access(1'b1, 32'h8000_0024, 4'hC, 32'hCAFE_F00D, 15, 1'b0, "wr_ack_at_limit");
    run_access(1'b0, 32'h8000_0024, 4'hF, 32'h0, 16, 1'b0, "rd_ack_past_limit");
    run_access(1'b1, 32'h8000_0028, 4'h3, 32'h0BAD_0BAD, 22, 1'b0, "wr_no_ack_late");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom
                                      : (BASE | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
      run_access(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, $urandom_range(1, 4),
                 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_sync_reset();
    int          rdy_n, we_n;
    logic [31:0] w;
    w = $urandom;
    rdy_n = 0; we_n = 0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0020; mem_byte_en = 4'hF; mem_wdata = w;
    step();
    mem_req = 1'b0;
    n_checks++;
    if (WB_WR_WE_O !== 1'b1) begin
      n_errors++; $display("FAIL sync_rst_we_issue: got %b expected 1", WB_WR_WE_O);
    end
    if (WB_WR_WE_O) slv_mem[WB_WR_ADR_O] = merge(slv_mem[WB_WR_ADR_O], WB_WR_DAT_O, WB_WR_SEL_O);
    ref_mem[8] = w;
    step();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    n_checks++;
    if ({req_ready, mem_ready} !== 2'b10) begin
      n_errors++; $display("FAIL sync_rst_idle: got ready=%b,%b expected 1,0", req_ready, mem_ready);
    end
    n_checks++;
    if ({WB_WR_SEL_O, WB_WR_DAT_O, WB_WR_ADR_O} !== '0) begin
      n_errors++;
      $display("FAIL sync_rst_clear: got sel=%h dat=%h adr=%h expected 0",
               WB_WR_SEL_O, WB_WR_DAT_O, WB_WR_ADR_O);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_ready) rdy_n++;
      if (WB_WR_WE_O) we_n++;
    end
    n_checks++;
    if (rdy_n !== 0 || we_n !== 0) begin
      n_errors++; $display("FAIL sync_rst_dropped: got ready=%0d we=%0d expected 0,0", rdy_n, we_n);
    end
    run_access(1'b0, 32'h8000_0020, 4'hF, 32'h0, 2, 1'b0, "load_after_sync_reset");
  endtask

  task automatic test_back_to_back();
    int          rdy_n, stb_n, bad;
    int          rdy_at [3];
    logic        prev_stb;
    logic [31:0] exp_d;
    rdy_n = 0; stb_n = 0; bad = 0; prev_stb = 1'b0;
    for (int k = 0; k < 3; k++) rdy_at[k] = -1;
    exp_d = ref_mem[16];
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0040; mem_byte_en = 4'hF;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      step();
      mem_req = (cyc < 12);
      if (mem_ready) begin
        if (rdy_n < 3) rdy_at[rdy_n] = cyc;
        rdy_n++;
        if (mem_rdata !== exp_d || mem_error !== 1'b0) bad++;
      end
      if (WB_RD_STB_O) stb_n++;
      WB_RD_ACK_I = prev_stb;
      WB_RD_DAT_I = prev_stb ? slv_mem[WB_RD_ADR_O] : $urandom;
      prev_stb    = WB_RD_STB_O;
    end
    WB_RD_ACK_I = 1'b0; mem_req = 1'b0;
    n_checks++;
    if (rdy_n !== 3 || stb_n !== 3) begin
      n_errors++; $display("FAIL b2b_counts: got ready=%0d stb=%0d expected 3,3", rdy_n, stb_n);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rdy_at[k] !== 3 + 4 * k) begin
        n_errors++; $display("FAIL b2b_slot%0d: got cycle %0d expected %0d", k, rdy_at[k], 3 + 4 * k);
      end
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL b2b_data: got %0d bad responses expected 0", bad);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    test_reset();
    test_directed();
    test_timeout();
    test_sync_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
